// File: rtl/ysyx_25070198_mem_resp.sv
`default_nettype none
// ============================================================================
// ysyx_25070198_mem_resp : word RAM responder for IFU fetch and LSU load/store
// Revision: 1.0
// ============================================================================
module ysyx_25070198_mem_resp #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_ren,
    input  logic [31:0] ifu_raddr,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rvalid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [29:0] mem_addr,
    input  logic [3:0]  mem_mask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_data_valid,
    output logic        bus_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [31:0] BASE_WORD = BASE >> 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [31:0] mem_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;     // 1 = data port, 0 = fetch port
    logic        write_q, write_d;
    logic        inr_q, inr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        req_data, req_any, req_write, req_inr;
    logic [31:0] req_idx;
    logic        cur_port, cur_read, cur_inr;
    logic [AW-1:0] cur_idx;
    logic [31:0] rd_word;
    logic        ram_we;

    assign req_data  = mem_ren | mem_wen;
    assign req_any   = req_data | ifu_ren;
    assign req_write = ~mem_ren & mem_wen;
    assign req_idx   = req_data ? ({2'b00, mem_addr} - BASE_WORD)
                                : ((ifu_raddr - BASE) >> 2);
    assign req_inr   = (req_idx < DEPTH_W);

    // In IDLE the live request is the one being accepted (matters for LATENCY=0).
    assign cur_port = (state_q == IDLE) ? req_data           : port_q;
    assign cur_read = (state_q == IDLE) ? ~req_write         : ~write_q;
    assign cur_inr  = (state_q == IDLE) ? req_inr            : inr_q;
    assign cur_idx  = (state_q == IDLE) ? req_idx[AW-1:0]    : idx_q;
    assign rd_word  = cur_inr ? mem_q[cur_idx] : 32'h0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        write_d     = write_q;
        inr_d       = inr_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        ifu_rdata_d = ifu_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    port_d  = req_data;
                    write_d = req_write;
                    idx_d   = req_idx[AW-1:0];
                    inr_d   = req_inr;
                    mask_d  = mem_mask;
                    wdata_d = mem_wdata;
                    if (!req_inr) begin
                        bus_err_d = 1'b1;
                    end
                    if (LATENCY > 0) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read data lands on the edge entering RESP so it coincides with valid.
        if ((state_d == RESP) && (state_q != RESP) && cur_read) begin
            if (cur_port) begin
                mem_rdata_d = rd_word;
            end else begin
                ifu_rdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            inr_q       <= 1'b0;
            idx_q       <= '0;
            mask_q      <= 4'd0;
            wdata_q     <= 32'h0;
            ifu_rdata_q <= 32'h0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            write_q     <= write_d;
            inr_q       <= inr_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            ifu_rdata_q <= ifu_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Reset forces state_q to IDLE, so an in-flight write can never reach RESP.
    assign ram_we = (state_q == RESP) && write_q && inr_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ifu_rdata      = ifu_rdata_q;
    assign mem_rdata      = mem_rdata_q;
    assign bus_err        = bus_err_q;
    assign ifu_rvalid     = (state_q == RESP) && !port_q;
    assign mem_data_valid = (state_q == RESP) && port_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25070198_mem_resp.sv
`default_nettype none
// ============================================================================
// tb_ysyx_25070198_mem_resp : directed bench, three responders at LATENCY 0/2/4
// Revision: 1.0
// ============================================================================
module tb_ysyx_25070198_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_ren = 1'b0;
    logic [31:0] ifu_raddr = 32'h0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [29:0] mem_addr = 30'h0;
    logic [3:0]  mem_mask = 4'h0;
    logic [31:0] mem_wdata = 32'h0;

    logic [31:0] ird0, ird2, ird4, mrd0, mrd2, mrd4;
    logic        iv0, iv2, iv4, mv0, mv2, mv4, er0, er2, er4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // All three share stimulus; each check targets the instance of interest.
    ysyx_25070198_mem_resp #(.LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .ifu_ren(ifu_ren), .ifu_raddr(ifu_raddr),
        .ifu_rdata(ird0), .ifu_rvalid(iv0), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mrd0), .mem_data_valid(mv0), .bus_err(er0));
    ysyx_25070198_mem_resp #(.LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .ifu_ren(ifu_ren), .ifu_raddr(ifu_raddr),
        .ifu_rdata(ird2), .ifu_rvalid(iv2), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mrd2), .mem_data_valid(mv2), .bus_err(er2));
    ysyx_25070198_mem_resp #(.LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .ifu_ren(ifu_ren), .ifu_raddr(ifu_raddr),
        .ifu_rdata(ird4), .ifu_rvalid(iv4), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rdata(mrd4), .mem_data_valid(mv4), .bus_err(er4));

    function automatic logic vld(input int s, input logic f);
        case (s)
            0:       return f ? iv0 : mv0;
            2:       return f ? iv2 : mv2;
            default: return f ? iv4 : mv4;
        endcase
    endfunction

    function automatic logic [31:0] rdat(input int s, input logic f);
        case (s)
            0:       return f ? ird0 : mrd0;
            2:       return f ? ird2 : mrd2;
            default: return f ? ird4 : mrd4;
        endcase
    endfunction

    function automatic logic err(input int s);
        case (s)
            0:       return er0;
            2:       return er2;
            default: return er4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One transaction on instance with LATENCY s; starts in an IDLE cycle.
    task automatic txn(input int s, input logic f, input logic wr,
                       input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input string tag);
        int n;
        if (f) begin
            ifu_ren   = 1'b1;
            ifu_raddr = a;
        end else begin
            mem_ren   = !wr;
            mem_wen   = wr;
            mem_addr  = a[29:0];
            mem_mask  = m;
            mem_wdata = wd;
        end
        n = 0;
        while (!vld(s, f) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(1 + s));
        chk({tag, ".other_valid"}, 32'(vld(s, !f)), 32'h0);
        if (!wr) chk({tag, ".rdata"}, rdat(s, f), erd);
        chk({tag, ".bus_err"}, 32'(err(s)), 32'(eerr));
        ifu_ren = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        tick();
        chk({tag, ".pulse_end"}, 32'(vld(s, f)), 32'h0);
        idle(6);
    endtask

    initial begin
        int n;
        int m;

        // Reset state
        idle(3);
        chk("rst.iv2", 32'(iv2), 32'h0);
        chk("rst.mv2", 32'(mv2), 32'h0);
        chk("rst.ird2", ird2, 32'h0);
        chk("rst.mrd2", mrd2, 32'h0);
        chk("rst.err2", 32'(er2), 32'h0);
        rst = 1'b1;

        // Basic fetch and masked write
        txn(2, 0, 1, 32'h2000_0000, 4'hF, 32'h0010_0093, 32'h0, 1'b0, "pre0");
        txn(2, 1, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0010_0093, 1'b0, "fetch0");
        txn(2, 0, 1, 32'h2000_0001, 4'hF, 32'h1122_3344, 32'h0, 1'b0, "pre1");
        txn(2, 0, 1, 32'h2000_0001, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0, "wmask");
        txn(2, 0, 0, 32'h2000_0001, 4'h0, 32'h0, 32'h1122_AB44, 1'b0, "raw");

        // Fetch and data read together: data first, fetch LATENCY+2 later
        ifu_ren   = 1'b1;
        ifu_raddr = 32'h8000_0004;
        mem_ren   = 1'b1;
        mem_addr  = 30'h2000_0000;
        n = 0;
        while (!mv2 && n < 20) begin tick(); n++; end
        chk("arb.data_lat", 32'(n), 32'd3);
        chk("arb.no_fetch_yet", 32'(iv2), 32'h0);
        chk("arb.data_rdata", mrd2, 32'h0010_0093);
        mem_ren = 1'b0;
        m = n;
        while (!iv2 && n < 30) begin tick(); n++; end
        chk("arb.fetch_gap", 32'(n - m), 32'd4);
        chk("arb.fetch_rdata", ird2, 32'h1122_AB44);
        chk("arb.one_valid", 32'(mv2), 32'h0);
        ifu_ren = 1'b0;
        idle(6);

        // Empty mask and the last in-range word
        txn(2, 0, 1, 32'h2000_0001, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, "mask0");
        txn(2, 0, 0, 32'h2000_0001, 4'h0, 32'h0, 32'h1122_AB44, 1'b0, "mask0_rd");
        txn(2, 0, 1, 32'h2000_0FFF, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0, "top_w");
        txn(2, 0, 0, 32'h2000_0FFF, 4'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, "top_r");

        // Out of range: below BASE and exactly DEPTH
        txn(2, 0, 0, 32'h1FFF_FFFF, 4'h0, 32'h0, 32'h0, 1'b1, "oor_rd");
        txn(2, 0, 1, 32'h2000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, "oor_w");
        txn(2, 0, 0, 32'h2000_0000, 4'h0, 32'h0, 32'h0010_0093, 1'b1, "no_alias");
        txn(2, 0, 0, 32'h2000_0001, 4'h0, 32'h0, 32'h1122_AB44, 1'b1, "after_err");

        // LATENCY = 0
        txn(0, 1, 0, 32'h8000_0000, 4'h0, 32'h0, 32'h0010_0093, 1'b1, "l0_fetch");
        txn(0, 0, 1, 32'h2000_0003, 4'hF, 32'h1357_2468, 32'h0, 1'b1, "l0_w");
        txn(0, 0, 0, 32'h2000_0003, 4'h0, 32'h0, 32'h1357_2468, 1'b1, "l0_raw");

        // LATENCY = 4, address changed while BUSY
        mem_ren  = 1'b1;
        mem_addr = 30'h2000_0000;
        tick();
        tick();
        mem_addr = 30'h2000_0001;
        n = 2;
        while (!mv4 && n < 20) begin tick(); n++; end
        chk("l4.lat", 32'(n), 32'd5);
        chk("l4.rdata", mrd4, 32'h0010_0093);
        mem_ren = 1'b0;
        idle(7);

        // Reset in the middle of a write on the LATENCY=4 instance
        txn(2, 0, 1, 32'h2000_0002, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1, "pre2");
        mem_wen   = 1'b1;
        mem_addr  = 30'h2000_0002;
        mem_mask  = 4'hF;
        mem_wdata = 32'hDEAD_BEEF;
        tick();
        tick();
        rst     = 1'b0;
        mem_wen = 1'b0;
        #1;
        chk("arst.mv4", 32'(mv4), 32'h0);
        chk("arst.iv4", 32'(iv4), 32'h0);
        chk("arst.mrd4", mrd4, 32'h0);
        chk("arst.ird4", ird4, 32'h0);
        chk("arst.err4", 32'(er4), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst.no_pulse", 32'(mv4 | iv4), 32'h0);
        end
        rst = 1'b1;
        txn(4, 0, 0, 32'h2000_0002, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "arst.rd4");
        txn(2, 0, 0, 32'h2000_0002, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "arst.rd2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25070198_mem_resp.md
Name: ysyx_25070198_mem_resp

Overview:
- Memory-side responder that services the core's instruction-fetch port and load/store port.
- Holds a word-organised RAM and arbitrates between the two requesters.
- Returns read data or write acknowledgements after a programmable latency, with a one-cycle valid pulse.
- Drives the `mem_data_valid` and `ifu_rdata` returns that the IFU and EXU wait on.

Parameters:
- BASE, 32'h80000000: byte address of word 0 of the RAM.
- DEPTH, 4096: number of 32-bit words.
- LATENCY, 2: extra wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- ifu_ren  input  1  fetch request; level-held until ifu_rvalid
- ifu_raddr  input  32  fetch byte address; bits [1:0] ignored
- ifu_rdata  output  32  fetched word; registered, holds its value until the next fetch response
- ifu_rvalid  output  1  one-cycle fetch response pulse
- mem_ren  input  1  data read request; level-held
- mem_wen  input  1  data write request; level-held
- mem_addr  input  30  data word address (byte address [31:2])
- mem_mask  input  4  byte-write enables; bit i selects wdata[8i+7:8i]
- mem_wdata  input  32  write data, already lane-aligned
- mem_rdata  output  32  loaded word; registered, holds its value until the next data read response
- mem_data_valid  output  1  one-cycle pulse acknowledging a data read or a data write
- bus_err  output  1  sticky flag; set by any out-of-range access

Behaviour:
- States: IDLE, BUSY, RESP. Counter cnt is 4 bits.
- IDLE, request arbitration:
  - Data port wins over fetch when both are present.
  - If mem_ren and mem_wen are both high, the read is taken and the write remains pending.
  - On acceptance, latch: port id, word index, mask, wdata, and kind (read/write).
  - Next state is BUSY with cnt=LATENCY-1 when LATENCY>0, otherwise RESP.
  - With no request present, stay in IDLE.
- BUSY: decrement cnt each cycle; go to RESP when cnt==0. Inputs are ignored, so changes to address or data after acceptance have no effect.
- RESP, lasting exactly one cycle:
  - The selected valid output is high.
  - For a read, the matching rdata register is loaded at the edge entering RESP, so data and valid are coincident.
  - For a write, the masked bytes are committed at the edge leaving RESP.
  - Next state is always IDLE.
- Timing: a request first seen in IDLE cycle c produces its valid pulse in cycle c+1+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
  - The requester must drop its ren/wen no later than the IDLE cycle following RESP; otherwise the responder treats it as a new request.
- Address mapping:
  - Fetch word index = (ifu_raddr - BASE) >> 2.
  - Data word index = mem_addr - (BASE >> 2).
  - Subtraction is 32-bit unsigned, so addresses below BASE wrap to large values and count as out of range.
- Out of range (index >= DEPTH):
  - The access is still answered with a normal valid pulse at normal latency.
  - A read returns 32'h0; a write is dropped.
  - bus_err is set and stays high until reset.
- mem_mask=4'b0000 on a write: acknowledged, no bytes change. Reads ignore mem_mask.
- Read-after-write to the same word in consecutive transactions returns the new data (the write commits before the next acceptance).
- Reset (rst low, asynchronous, any state including mid-BUSY):
  - State returns to IDLE and cnt to 0.
  - ifu_rvalid=0, mem_data_valid=0, ifu_rdata=0, mem_rdata=0, bus_err=0.
  - An in-flight write is discarded.
  - RAM contents are not reset.
  - After rst rises, the first acceptance can occur on the first clock edge.
- Valid outputs are never high in IDLE or BUSY. At most one valid output is high in any cycle.

Test Plan:
- LATENCY=2. Preload word 0 = 32'h00100093. Hold ifu_ren=1, ifu_raddr=32'h80000000 from cycle 0 → ifu_rvalid high only in cycle 3 with ifu_rdata=32'h00100093; mem_data_valid stays 0.
- Write mem_addr=30'h20000001, mem_mask=4'b0010, mem_wdata=32'h0000AB00 onto word 32'h11223344 → mem_data_valid pulses once. A following read of the same address returns 32'h1122AB44.
- ifu_ren and mem_ren raised in the same cycle → the data response arrives first at c+1+LATENCY. The fetch (still held) is accepted in the next IDLE cycle and responds LATENCY+2 cycles after the data response.
- Data read at byte address 32'h7FFFFFFC (mem_addr=30'h1FFFFFFF) → mem_data_valid pulses with mem_rdata=0 and bus_err=1. A subsequent in-range read succeeds while bus_err stays 1.
- LATENCY=0 → valid in cycle c+1. Changing mem_addr during BUSY with LATENCY=4 does not change the returned data.
- Assert rst low during BUSY of a write → no valid pulse appears and all outputs are 0. After release, a read of the target word returns its pre-write value.
